// File: rtl/sc_register_car.sv
// rtl/sc_register_car.sv - car row register with road-edge saturation and a sticky active-low lose flag
module sc_register_car #(
    parameter int                   DATAWIDTH    = 8,
    parameter int                   POSWIDTH     = 3,
    parameter logic [DATAWIDTH-1:0] INIT_PATTERN = 8'b00011000
) (
    input  logic                 SC_REGISTER_CAR_CLOCK_50,
    input  logic                 SC_REGISTER_CAR_RESET_InHigh,
    input  logic                 SC_REGISTER_CAR_CLEAR_InLow,
    input  logic                 SC_REGISTER_CAR_LOAD_InLow,
    input  logic [1:0]           SC_REGISTER_CAR_SHIFT_InBUS,
    input  logic [DATAWIDTH-1:0] SC_REGISTER_CAR_OBSTACLE_InBUS,
    output logic [DATAWIDTH-1:0] SC_REGISTER_CAR_DATA_OutBUS,
    output logic [POSWIDTH-1:0]  SC_REGISTER_CAR_POSITION_OutBUS,
    output logic                 SC_REGISTER_CAR_BLOCKED_Out,
    output logic                 SC_REGISTER_CAR_LOSE_OutLow
);

    localparam logic [1:0] SHIFT_RIGHT = 2'b10;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;

    logic [DATAWIDTH-1:0] data_reg;
    logic [DATAWIDTH-1:0] data_next;
    logic [POSWIDTH-1:0]  pos_reg;
    logic [POSWIDTH-1:0]  pos_next;
    logic                 blocked_reg;
    logic                 blocked_next;
    logic                 lose_reg;
    logic                 lose_next;

    logic                 row_empty;
    logic                 at_right_edge;
    logic                 at_left_edge;
    logic                 collision;

    // Index of the lowest set bit; an empty row reports 0.
    function automatic logic [POSWIDTH-1:0] lowest_set(input logic [DATAWIDTH-1:0] row);
        logic [POSWIDTH-1:0] idx;
        idx = '0;
        for (int i = DATAWIDTH - 1; i >= 0; i--) begin
            if (row[i]) begin
                idx = POSWIDTH'(i);
            end
        end
        return idx;
    endfunction

    assign row_empty     = (data_reg == '0);
    assign at_right_edge = data_reg[0];
    assign at_left_edge  = data_reg[DATAWIDTH-1];
    assign collision     = |(data_reg & SC_REGISTER_CAR_OBSTACLE_InBUS);

    always_comb begin
        data_next    = data_reg;
        blocked_next = 1'b0;
        lose_next    = lose_reg & ~collision;

        if (!SC_REGISTER_CAR_CLEAR_InLow) begin
            data_next = '0;
            lose_next = 1'b1;
        end else if (!SC_REGISTER_CAR_LOAD_InLow) begin
            data_next = INIT_PATTERN;
            lose_next = 1'b1;
        end else begin
            // An empty row has no car to move, so it neither shifts nor reports a block.
            case (SC_REGISTER_CAR_SHIFT_InBUS)
                SHIFT_RIGHT: begin
                    if (!row_empty) begin
                        if (at_right_edge) begin
                            blocked_next = 1'b1;
                        end else begin
                            data_next = data_reg >> 1;
                        end
                    end
                end
                SHIFT_LEFT: begin
                    if (!row_empty) begin
                        if (at_left_edge) begin
                            blocked_next = 1'b1;
                        end else begin
                            data_next = data_reg << 1;
                        end
                    end
                end
                default: begin
                    data_next = data_reg;
                end
            endcase
        end

        pos_next = lowest_set(data_next);
    end

    always_ff @(posedge SC_REGISTER_CAR_CLOCK_50) begin
        if (SC_REGISTER_CAR_RESET_InHigh) begin
            data_reg    <= '0;
            pos_reg     <= '0;
            blocked_reg <= 1'b0;
            lose_reg    <= 1'b1;
        end else begin
            data_reg    <= data_next;
            pos_reg     <= pos_next;
            blocked_reg <= blocked_next;
            lose_reg    <= lose_next;
        end
    end

    assign SC_REGISTER_CAR_DATA_OutBUS     = data_reg;
    assign SC_REGISTER_CAR_POSITION_OutBUS = pos_reg;
    assign SC_REGISTER_CAR_BLOCKED_Out     = blocked_reg;
    assign SC_REGISTER_CAR_LOSE_OutLow     = lose_reg;

endmodule

// File: tb/tb_sc_register_car.sv
// tb/tb_sc_register_car.sv - scoreboard bench for sc_register_car against a behavioural car model
module tb_sc_register_car;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr_n = 1'b1;
    logic       ld_n = 1'b1;
    logic [1:0] shift = 2'b11;
    logic [7:0] obstacle = 8'h00;
    logic [7:0] data_out;
    logic [2:0] pos_out;
    logic       blocked_out;
    logic       lose_n_out;

    sc_register_car dut (
        .SC_REGISTER_CAR_CLOCK_50        (clk),
        .SC_REGISTER_CAR_RESET_InHigh    (rst),
        .SC_REGISTER_CAR_CLEAR_InLow     (clr_n),
        .SC_REGISTER_CAR_LOAD_InLow      (ld_n),
        .SC_REGISTER_CAR_SHIFT_InBUS     (shift),
        .SC_REGISTER_CAR_OBSTACLE_InBUS  (obstacle),
        .SC_REGISTER_CAR_DATA_OutBUS     (data_out),
        .SC_REGISTER_CAR_POSITION_OutBUS (pos_out),
        .SC_REGISTER_CAR_BLOCKED_Out     (blocked_out),
        .SC_REGISTER_CAR_LOSE_OutLow     (lose_n_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [7:0] pos;
        logic       blk;
        logic       lose_n;
        int         step;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    // Model state: the car row as a plain number, leftmost column worth 128.
    int   m_row  = 0;
    bit   m_lose = 1'b0;

    function automatic int low_idx(input int v);
        if (v == 0) return 0;
        for (int p = 0; p < 8; p++) begin
            if (((v >> p) & 1) == 1) return p;
        end
        return 0;
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want, input int stp);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s step=%0d got=%b expected=%b", name, stp, got, want);
        end
    endtask

    task automatic step(input bit r, input bit c_n, input bit l_n, input logic [1:0] sh, input logic [7:0] obs);
        exp_t e;
        bit   blk;
        bit   hit;
        @(negedge clk);
        rst = r; clr_n = c_n; ld_n = l_n; shift = sh; obstacle = obs;
        blk = 1'b0;
        if (r || !c_n) begin
            m_row = 0; m_lose = 1'b0;
        end else if (!l_n) begin
            m_row = 24; m_lose = 1'b0;
        end else begin
            hit = (m_row & int'(obs)) != 0;
            if (sh == 2'b10 && m_row != 0) begin
                if (m_row % 2 == 0) m_row = m_row / 2;
                else blk = 1'b1;
            end else if (sh == 2'b01 && m_row != 0) begin
                if (m_row < 128) m_row = m_row * 2;
                else blk = 1'b1;
            end
            if (hit) m_lose = 1'b1;
        end
        e.data   = 8'(m_row);
        e.pos    = 8'(low_idx(m_row));
        e.blk    = blk;
        e.lose_n = ~m_lose;
        e.step   = step_no;
        step_no++;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 1, 2'b11, 8'h00);
    endtask

    // Monitor: every edge presents a new output word, compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("data", data_out, e.data, e.step);
                chk("position", {5'b0, pos_out}, e.pos, e.step);
                chk("blocked", {7'b0, blocked_out}, {7'b0, e.blk}, e.step);
                chk("lose_n", {7'b0, lose_n_out}, {7'b0, e.lose_n}, e.step);
            end
        end
    end

    initial begin
        logic [7:0] obs;
        logic [1:0] sh;
        bit r, c_n, l_n;

        step(1, 1, 1, 2'b11, 8'h00);
        step(1, 1, 1, 2'b11, 8'h00);
        step(0, 1, 0, 2'b11, 8'h00);
        idle(1);

        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1, 2'b10, 8'h00);
            idle(1);
        end

        step(0, 1, 0, 2'b11, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1, 2'b01, 8'h00);
            idle(1);
        end
        step(0, 1, 1, 2'b01, 8'h00);
        step(0, 1, 1, 2'b01, 8'h00);

        step(0, 1, 0, 2'b11, 8'h00);
        step(0, 1, 1, 2'b11, 8'h10);
        step(0, 1, 1, 2'b11, 8'h00);
        idle(3);
        step(0, 0, 1, 2'b11, 8'h00);
        idle(1);

        step(0, 1, 0, 2'b11, 8'h00);
        step(0, 0, 0, 2'b01, 8'hFF);
        step(0, 1, 0, 2'b10, 8'h00);
        step(0, 1, 1, 2'b10, 8'h00);
        step(0, 1, 1, 2'b10, 8'h00);
        step(0, 1, 1, 2'b11, 8'h04);
        idle(1);
        step(1, 1, 1, 2'b01, 8'h00);
        idle(1);

        step(0, 1, 1, 2'b10, 8'h00);
        step(0, 1, 1, 2'b01, 8'h00);
        step(0, 1, 0, 2'b11, 8'h00);

        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 99) == 0);
            c_n = ($urandom_range(0, 39) != 0);
            l_n = ($urandom_range(0, 29) != 0);
            sh  = 2'($urandom_range(0, 3));
            obs = 8'h00;
            if ($urandom_range(0, 3) == 0) obs = 8'h01 << $urandom_range(0, 7);
            step(r, c_n, l_n, sh, obs);
        end

        idle(1);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_register_car.md
# sc_register_car

Car position register for the RoadFighter datapath. It receives the car state machine's command interface: active-low clear, active-low load, and the 2-bit shift bus. It holds the car's row pattern on the LED matrix and saturates moves at the road edges. It compares the car row against the incoming obstacle row and returns the registered, sticky, active-low lose flag that the car state machine samples in its ready state.

## Interface
- DATAWIDTH, 8, width of the car row in LED columns.
- POSWIDTH, 3, width of the position index; must satisfy 2^POSWIDTH ≥ DATAWIDTH.
- INIT_PATTERN, 8'b00011000, row pattern loaded at game start; bit DATAWIDTH-1 is the leftmost column.

Ports:
- SC_REGISTER_CAR_CLOCK_50  in  1  system clock; all state changes on its rising edge.
- SC_REGISTER_CAR_RESET_InHigh  in  1  synchronous, active-high reset.
- SC_REGISTER_CAR_CLEAR_InLow  in  1  active-low clear command from the car state machine.
- SC_REGISTER_CAR_LOAD_InLow  in  1  active-low load command from the car state machine.
- SC_REGISTER_CAR_SHIFT_InBUS  in  2  shift command: 2'b10 = shift right, 2'b01 = shift left, 2'b11 = hold, 2'b00 = hold (reserved).
- SC_REGISTER_CAR_OBSTACLE_InBUS  in  DATAWIDTH  obstacle pattern currently occupying the car's row.
- SC_REGISTER_CAR_DATA_OutBUS  out  DATAWIDTH  registered car row pattern.
- SC_REGISTER_CAR_POSITION_OutBUS  out  POSWIDTH  registered index of the lowest set bit of the car row; 0 when the row is empty.
- SC_REGISTER_CAR_BLOCKED_Out  out  1  one-cycle pulse when a shift command was rejected at a road edge.
- SC_REGISTER_CAR_LOSE_OutLow  out  1  registered, sticky, active-low collision flag.

## Operation
- One clock domain; synchronous, active-high reset. No asynchronous paths.
- Command priority, evaluated every cycle: reset > clear > load > shift > hold.
- Reset or clear (CLEAR_InLow=0):
  - DATA=0, POSITION=0, BLOCKED=0, LOSE_OutLow=1.
- Load (LOAD_InLow=0, CLEAR_InLow=1):
  - DATA=INIT_PATTERN; POSITION is set to the index of INIT_PATTERN's lowest set bit.
  - LOSE_OutLow=1, BLOCKED=0.
  - Any shift command in the same cycle is ignored.
- Shift right (2'b10):
  - If DATA[0]=0: DATA = DATA>>1 (zero fill) and POSITION decrements.
  - Else DATA is unchanged and BLOCKED=1 for one cycle.
- Shift left (2'b01):
  - If DATA[DATAWIDTH-1]=0: DATA = DATA<<1 (zero fill) and POSITION increments.
  - Else DATA is unchanged and BLOCKED=1 for one cycle.
- Hold (2'b11 or 2'b00): DATA and POSITION are unchanged; BLOCKED=0.
- A shift command applied to an empty row (DATA=0) leaves the row unchanged and does not pulse BLOCKED.
- Each cycle in which the shift bus reads 2'b10 or 2'b01 is one move. The state machine issues single-cycle shift pulses; a held code moves the car once per cycle.
- Collision: in any cycle without reset, clear or load, if (DATA_OutBUS & OBSTACLE_InBUS) ≠ 0, LOSE_OutLow becomes 0 at the next edge.
- LOSE_OutLow stays 0 until reset, clear or load; it never self-clears. Moves continue to be processed while it is 0.
- POSITION is computed from the next value of DATA and registered in the same edge, so it never lags DATA.

## Timing
- All outputs are registered. A command sampled at edge N is visible on the outputs after edge N; latency is 1 cycle.
- Collision detection uses registered DATA and the live obstacle input. If the overlap is present before edge N, LOSE_OutLow=0 after edge N.
- End-to-end lose path: car FSM in its ready state sees LOSE_InLow=0, goes to its reset state, then drives CLEAR_InLow=0. This block then releases LOSE_OutLow=1 one cycle later.
- A clear or load in the same cycle as an overlap takes priority: LOSE_OutLow stays 1.
- CLEAR_InLow=0 and LOAD_InLow=0 together: clear wins and DATA=0.
- Reset asserted mid-move: the move is discarded and all outputs take their reset values at that edge.
- BLOCKED is high for exactly one cycle per rejected command and is never asserted in the same cycle as a DATA change.

## Test plan
- Reset then load: assert reset, then pulse LOAD_InLow=0 for one cycle → DATA=8'b00011000, POSITION=3, LOSE_OutLow=1, BLOCKED=0.
- Right edge: after load, issue five single-cycle 2'b10 pulses.
  - First three pulses → DATA=8'b00001100, 8'b00000110, 8'b00000011.
  - Fourth and fifth pulses → DATA stays 8'b00000011, POSITION=0, BLOCKED pulses once per rejected command.
- Left edge: after load, issue five 2'b01 pulses → DATA=8'b11000000, POSITION=6, BLOCKED pulses on the fourth and fifth commands.
- Collision: after load, drive OBSTACLE=8'b00010000.
  - One cycle later LOSE_OutLow=0; it holds 0 after OBSTACLE returns to 0.
  - Pulse CLEAR_InLow=0 → DATA=0 and LOSE_OutLow=1 the next cycle.
- Priority: in one cycle, drive CLEAR_InLow=0, LOAD_InLow=0 and SHIFT=2'b01 with an overlapping obstacle → DATA=0 and LOSE_OutLow=1.
  - Then LOAD_InLow=0 with SHIFT=2'b10 → DATA=8'b00011000 and no shift.
- Reset mid-game: with DATA=8'b00000110 and LOSE_OutLow=0, assert reset while SHIFT=2'b01 → DATA=0, POSITION=0, BLOCKED=0, LOSE_OutLow=1 after that edge.
